// File: rtl/io_pkg.sv
// Shared constants for the board-I/O slave: register offsets and bus width.
package io_pkg;
    localparam int BUS_W = 32;

    localparam logic [4:0] ADDR_LED      = 5'h00;
    localparam logic [4:0] ADDR_DIP      = 5'h04;
    localparam logic [4:0] ADDR_DATA     = 5'h08;
    localparam logic [4:0] ADDR_CHG      = 5'h0C;
    localparam logic [4:0] ADDR_CYCLES   = 5'h10;
    localparam logic [4:0] ADDR_IRQ_MASK = 5'h14;

    // Byte offset with the sub-word bits dropped.
    function automatic logic [4:0] word_off(input logic [4:0] addr);
        return {addr[4:2], 2'b00};
    endfunction
endpackage

// File: rtl/mmio_board_io_if.sv
// Core data-bus port of the board-I/O slave; one request, one READY pulse.
interface mmio_board_io_if;
    import io_pkg::*;
    logic             BUS_REQ;
    logic             BUS_WE;
    logic [4:0]       BUS_ADDR;
    logic [BUS_W-1:0] BUS_WDATA;
    logic [BUS_W-1:0] BUS_RDATA;
    logic             BUS_READY;

    modport master (output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, input BUS_RDATA, BUS_READY);
    modport slave  (input BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, output BUS_RDATA, BUS_READY);
endinterface

// File: rtl/dip_debounce.sv
// Two-flop synchroniser plus whole-vector debounce; stable follows raw after 2+DEBOUNCE_CYCLES edges.
module dip_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DIP_W           = 7
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DIP_W-1:0] raw,
    output logic [DIP_W-1:0] stable,
    output logic             change_pulse
);
    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [DIP_W-1:0] r_sync1, r_sync2, r_stable;
    logic [15:0]      r_cnt;
    logic             w_differ;

    assign w_differ     = (r_sync2 != r_stable);
    assign change_pulse = w_differ && (r_cnt == LAST);
    assign stable       = r_stable;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (change_pulse) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/mmio_board_io.sv
// Board-I/O MMIO slave: LED/DATA/CYCLES registers, debounced DIP, change flag.
// MMIO_BOARD_IO_DIP_IRQ_EN adds the DIP_IRQ output and the IRQ_MASK register.
module mmio_board_io
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DIP_W           = 7,
    parameter int LED_W           = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DIP_W-1:0] DIP,
    mmio_board_io_if.slave   bus,
    output logic [LED_W-1:0] LED,
    output logic [BUS_W-1:0] DATA
`ifdef MMIO_BOARD_IO_DIP_IRQ_EN
    ,output logic            DIP_IRQ
`endif
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    logic [0:0]       r_state;
    logic [BUS_W-1:0] r_rdata, r_data, r_cycles;
    logic [LED_W-1:0] r_led;
    logic             r_chg;
    logic [DIP_W-1:0] w_dip_stable;
    logic             w_chg_set, w_accept, w_wr, w_unused;
    logic [4:0]       w_off;
    logic [BUS_W-1:0] w_rd_val;

    dip_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DIP_W(DIP_W)) u_dip (
        .CLK         (CLK),
        .RESET       (RESET),
        .raw         (DIP),
        .stable      (w_dip_stable),
        .change_pulse(w_chg_set)
    );

    assign w_accept = bus.BUS_REQ && (r_state == S_IDLE);
    assign w_wr     = w_accept && bus.BUS_WE;
    assign w_off    = word_off(bus.BUS_ADDR);
    assign w_unused = ^bus.BUS_ADDR[1:0];

`ifdef MMIO_BOARD_IO_DIP_IRQ_EN
    logic r_irq_mask, r_chg_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_irq_mask <= 1'b0;
            r_chg_q    <= 1'b0;
        end else begin
            r_chg_q <= r_chg;
            if (w_wr && w_off == ADDR_IRQ_MASK) r_irq_mask <= bus.BUS_WDATA[0];
        end
    end

    assign DIP_IRQ = r_chg_q & r_irq_mask;
`endif

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            ADDR_LED:      w_rd_val[LED_W-1:0] = r_led;
            ADDR_DIP:      w_rd_val[DIP_W-1:0] = w_dip_stable;
            ADDR_DATA:     w_rd_val = r_data;
            ADDR_CHG:      w_rd_val[0] = r_chg;
            ADDR_CYCLES:   w_rd_val = r_cycles;
`ifdef MMIO_BOARD_IO_DIP_IRQ_EN
            ADDR_IRQ_MASK: w_rd_val[0] = r_irq_mask;
`endif
            default:       w_rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_rdata  <= '0;
            r_led    <= '0;
            r_data   <= '0;
            r_chg    <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_state <= w_accept ? S_RESP : S_IDLE;
            if (w_accept) r_rdata <= w_rd_val;
            if (w_wr && w_off == ADDR_LED)  r_led  <= bus.BUS_WDATA[LED_W-1:0];
            if (w_wr && w_off == ADDR_DATA) r_data <= bus.BUS_WDATA;
            if (w_wr && w_off == ADDR_CYCLES) r_cycles <= bus.BUS_WDATA;
            else                              r_cycles <= r_cycles + 32'd1;
            // A debounce event in the same cycle as a W1C keeps the flag set.
            if (w_chg_set)                                         r_chg <= 1'b1;
            else if (w_wr && w_off == ADDR_CHG && bus.BUS_WDATA[0]) r_chg <= 1'b0;
        end
    end

    assign bus.BUS_READY = (r_state == S_RESP);
    assign bus.BUS_RDATA = (r_state == S_RESP) ? r_rdata : '0;
    assign LED           = r_led;
    assign DATA          = r_data;
endmodule

// File: tb/tb_mmio_board_io.sv
// Directed bench for mmio_board_io: register vector table plus timing sequences.
module tb_mmio_board_io;
    logic        CLK;
    logic        RESET;
    logic [6:0]  DIP;
    logic [15:0] LED;
    logic [31:0] DATA;
`ifdef MMIO_BOARD_IO_DIP_IRQ_EN
    logic        DIP_IRQ;
`endif

    mmio_board_io_if bus();

    mmio_board_io #(.DEBOUNCE_CYCLES(16), .DIP_W(7), .LED_W(16)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .DIP  (DIP),
        .bus  (bus),
        .LED  (LED),
        .DATA (DATA)
`ifdef MMIO_BOARD_IO_DIP_IRQ_EN
        ,.DIP_IRQ(DIP_IRQ)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[14];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] rd, cap_led, cap_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge with BUS_READY low.
    task automatic bus_op(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata);
        int n;
        bus.BUS_REQ   = 1'b1;
        bus.BUS_WE    = we;
        bus.BUS_ADDR  = addr;
        bus.BUS_WDATA = wd;
        tick();
        bus.BUS_REQ = 1'b0;
        n = 0;
        while (bus.BUS_READY !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        check("bus_ready", {31'b0, bus.BUS_READY}, 32'd1);
        rdata    = bus.BUS_RDATA;
        cap_led  = {16'b0, LED};
        cap_data = DATA;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int pulses;
        vecs[0]  = '{1'b1, 5'h08, 32'hDEADBEEF, 32'h0,        16'h0000, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 5'h08, 32'h0,        32'hDEADBEEF, 16'h0000, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'h00, 32'h0001A5A5, 32'h0,        16'hA5A5, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'h00, 32'h0,        32'h0000A5A5, 16'hA5A5, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 5'h1C, 32'h0,        32'h0,        16'hA5A5, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 5'h1C, 32'h12345678, 32'h0,        16'hA5A5, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 5'h04, 32'h0,        32'h0,        16'hA5A5, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 5'h0C, 32'h0,        32'h0,        16'hA5A5, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 5'h14, 32'h0,        32'h0,        16'hA5A5, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 5'h00, 32'h12345678, 32'h0,        16'h5678, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 5'h03, 32'h0,        32'h00005678, 16'h5678, 32'hDEADBEEF};
        vecs[11] = '{1'b0, 5'h0B, 32'h0,        32'hDEADBEEF, 16'h5678, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 5'h0A, 32'h00C0FFEE, 32'h0,        16'h5678, 32'h00C0FFEE};
        vecs[13] = '{1'b0, 5'h08, 32'h0,        32'h00C0FFEE, 16'h5678, 32'h00C0FFEE};

        RESET = 1'b1;
        DIP   = 7'd0;
        bus.BUS_REQ = 1'b0; bus.BUS_WE = 1'b0; bus.BUS_ADDR = 5'd0; bus.BUS_WDATA = 32'd0;
        repeat (5) tick();
        check("rst_led",   {16'b0, LED}, 32'h0);
        check("rst_data",  DATA, 32'h0);
        check("rst_ready", {31'b0, bus.BUS_READY}, 32'h0);
        check("rst_rdata", bus.BUS_RDATA, 32'h0);
`ifdef MMIO_BOARD_IO_DIP_IRQ_EN
        check("rst_irq", {31'b0, DIP_IRQ}, 32'h0);
`endif
        RESET = 1'b0;

        // Three edges out of reset, then the acceptance edge captures 3.
        repeat (3) tick();
        bus_op(1'b0, 5'h10, 32'h0, rd); check("cycles_first", rd, 32'd3);
        bus_op(1'b0, 5'h10, 32'h0, rd); check("cycles_second", rd, 32'd5);

        for (int i = 0; i < 14; i++) begin
            bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_led", i), cap_led, {16'b0, vecs[i].exp_led});
            check($sformatf("vec%0d_data", i), cap_data, vecs[i].exp_data);
        end

        // REQ held for 6 edges: accepted on edges 1, 3 and 5 only.
        pulses = 0;
        bus.BUS_REQ = 1'b1; bus.BUS_WE = 1'b0; bus.BUS_ADDR = 5'h08;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.BUS_READY === 1'b1) pulses++;
        end
        bus.BUS_REQ = 1'b0;
        check("req_held_pulses", pulses, 32'd3);
        tick();
        check("req_held_idle", {31'b0, bus.BUS_READY}, 32'h0);

        bus_op(1'b1, 5'h10, 32'hFFFFFFFF, rd);
        bus_op(1'b0, 5'h10, 32'h0, rd); check("cycles_wrap0", rd, 32'd0);
        bus_op(1'b0, 5'h10, 32'h0, rd); check("cycles_wrap2", rd, 32'd2);

        // DIP 0 -> 1: stable flips at the 18th edge after the change.
        DIP = 7'b0000001;
        repeat (16) tick();
        bus_op(1'b0, 5'h04, 32'h0, rd); check("dip_edge17", rd, 32'h0);
        bus_op(1'b0, 5'h04, 32'h0, rd); check("dip_edge19", rd, 32'h1);
        bus_op(1'b0, 5'h0C, 32'h0, rd); check("chg_set", rd, 32'h1);
        bus_op(1'b1, 5'h0C, 32'h0, rd);
        bus_op(1'b0, 5'h0C, 32'h0, rd); check("chg_w0_noeffect", rd, 32'h1);
        bus_op(1'b1, 5'h0C, 32'h1, rd);
        bus_op(1'b0, 5'h0C, 32'h0, rd); check("chg_w1c", rd, 32'h0);

        DIP = 7'b0000010;
        repeat (10) tick();
        DIP = 7'b0000001;
        repeat (30) tick();
        bus_op(1'b0, 5'h04, 32'h0, rd); check("glitch_dip", rd, 32'h1);
        bus_op(1'b0, 5'h0C, 32'h0, rd); check("glitch_chg", rd, 32'h0);

        // W1C accepted on the same edge the debounce sets the flag.
        DIP = 7'b0000000;
        repeat (17) tick();
        bus_op(1'b1, 5'h0C, 32'h1, rd);
        bus_op(1'b0, 5'h0C, 32'h0, rd); check("chg_set_wins", rd, 32'h1);
        bus_op(1'b0, 5'h04, 32'h0, rd); check("dip_back0", rd, 32'h0);

        // Reset arriving with a write pending: nothing lands, READY stays low.
        bus.BUS_REQ = 1'b1; bus.BUS_WE = 1'b1; bus.BUS_ADDR = 5'h00; bus.BUS_WDATA = 32'hBEEF;
        #2 RESET = 1'b1;
        #1 check("rstmid_led_async", {16'b0, LED}, 32'h0);
        tick();
        check("rstmid_ready", {31'b0, bus.BUS_READY}, 32'h0);
        RESET = 1'b0;
        bus.BUS_REQ = 1'b0;
        tick();
        check("rstmid_led", {16'b0, LED}, 32'h0);
        check("rstmid_ready2", {31'b0, bus.BUS_READY}, 32'h0);

`ifdef MMIO_BOARD_IO_DIP_IRQ_EN
        bus_op(1'b1, 5'h14, 32'h1, rd);
        bus_op(1'b0, 5'h14, 32'h0, rd); check("irq_mask_rd", rd, 32'h1);
        DIP = 7'b0000001;
        repeat (18) tick();
        check("irq_lag", {31'b0, DIP_IRQ}, 32'h0);
        tick();
        check("irq_rise", {31'b0, DIP_IRQ}, 32'h1);
        bus_op(1'b1, 5'h0C, 32'h1, rd);
        check("irq_clear", {31'b0, DIP_IRQ}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mmio_board_io.md
Name: mmio_board_io

Overview:
- Memory-mapped board-I/O slave between the RISC-V core's data bus and the FPGA board pins.
- Holds the 16-bit LED register and the 32-bit DATA display register.
- Synchronises and debounces the 7 DIP switches.
- Keeps a DIP-change flag and a free-running cycle counter.
- Instantiated inside the top wrapper; drives the top-level LED and DATA pins directly.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised DIP value must differ from the stable value before it is accepted (legal range 2..65535).
- DIP_W, 7: DIP switch count.
- LED_W, 16: LED count.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-high.
- DIP  in  DIP_W  raw switch inputs, asynchronous to CLK.
- BUS_REQ  in  1  transaction request.
- BUS_WE  in  1  1 = write, 0 = read; sampled with BUS_REQ.
- BUS_ADDR  in  5  byte offset; bits [1:0] ignored.
- BUS_WDATA  in  32  write data.
- BUS_RDATA  out  32  read data; valid only while BUS_READY = 1, otherwise 0.
- BUS_READY  out  1  one-cycle completion pulse.
- LED  out  LED_W  LED register.
- DATA  out  32  display register.
- DIP_IRQ  out  1  change interrupt; present only with DIP_IRQ_EN.

Behaviour:
- Reset: one clock, CLK; reset is asynchronous and active-high (port RESET).
  - While RESET = 1, all outputs are 0: LED, DATA, BUS_RDATA, BUS_READY, DIP_IRQ.
  - Also cleared: sync flops, stable DIP, debounce count, CHG flag, CYCLES.
  - RESET during an accepted transaction drops the pending BUS_READY. No write that has not already taken effect is applied.
- Register map (word offsets):
  - 0x00 LED: RW, bits [15:0]; upper bits read 0.
  - 0x04 DIP: RO, debounced stable value in [6:0].
  - 0x08 DATA: RW, 32 bits.
  - 0x0C CHG: bit0, write-1-to-clear.
  - 0x10 CYCLES: RW, 32 bits.
  - Any other offset: reads 0, writes ignored; BUS_READY still pulses.
- Bus handshake:
  - A request is accepted on a rising edge where BUS_REQ = 1 and BUS_READY = 0.
  - BUS_READY = 1 exactly one cycle after acceptance, for one cycle.
  - BUS_RDATA carries the register value captured at the acceptance edge.
  - BUS_REQ held high through the READY cycle is not accepted again until the next edge, so the maximum rate is one transaction per 2 cycles.
  - A write updates its register at the acceptance edge; LED/DATA show the new value in the cycle BUS_READY is high.
- DIP path:
  - Two-flop synchroniser, then the debounce block.
  - Counter increments every cycle the synchronised value differs from the stable value, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing: stable <= synchronised, counter <= 0, CHG <= 1.
  - Raw-to-stable latency = 2 + DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
  - Any bit change in the vector restarts nothing; the vector is compared as a whole.
- CHG flag:
  - Writing bit0 = 1 clears it; writing bit0 = 0 has no effect.
  - A set event and a clear in the same cycle leave CHG = 1 (set wins).
- CYCLES: increments by 1 every cycle and wraps 0xFFFFFFFF -> 0. A write loads BUS_WDATA and wins over the increment in that cycle.

Optional Feature:
- Macro: MMIO_BOARD_IO_DIP_IRQ_EN.
- Defined: DIP_IRQ port exists, DIP_IRQ = CHG registered (one-cycle lag), level output; it clears the cycle after CHG is cleared. Address 0x14 IRQ_MASK (bit0, RW, reset 0) gates it: DIP_IRQ = CHG_q & mask.
- Undefined: no DIP_IRQ port, no 0x14 register (reads 0), no extra flops.

Decomposition:
- Shared package io_pkg:
  - Address offsets: ADDR_LED, ADDR_DIP, ADDR_DATA, ADDR_CHG, ADDR_CYCLES, ADDR_IRQ_MASK.
  - Bus width constant 32.
- Sub-module dip_debounce: synchroniser + counter. Ports CLK, RESET, raw, stable, change_pulse; parameters DEBOUNCE_CYCLES, DIP_W.
- The register file and bus FSM (IDLE/RESP) stay in mmio_board_io.

Test Plan:
- Reset then idle: RESET high 5 cycles -> LED = 0, DATA = 0, BUS_READY = 0. Read 0x10 after release at cycle N -> value N-1 (±1 per the defined capture edge).
- Write 0x08 = 0xDEADBEEF, read back -> DATA = 0xDEADBEEF the cycle BUS_READY pulses; read returns 0xDEADBEEF. Write 0x00 = 0x0001A5A5 -> LED = 0xA5A5, readback 0x0000A5A5.
- DIP = 7'b0000001 held 50 cycles -> 0x04 reads 0x01 after exactly 18 edges, CHG = 1. Write 0x0C = 1 -> CHG = 0.
- DIP glitch 7'b0000010 for 10 cycles then back -> 0x04 unchanged, CHG stays 0.
- BUS_REQ held high 6 cycles -> exactly 3 BUS_READY pulses. Read 0x1C -> 0 with READY. Write 0x10 = 0xFFFFFFFF -> next reads show wrap through 0.
- With macro defined: mask = 1, DIP toggle -> DIP_IRQ rises one cycle after CHG. Simultaneous set and W1C -> CHG stays 1.
